// File: rtl/register_token_parser.sv
// Streaming register-operand parser: r/x-prefixed decimal indices and ABI aliases,
// one ASCII character per strobe, one-cycle done pulse per token, sticky error.
module register_token_parser #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MAX_DIGITS = 2,
  parameter int unsigned ACCEPT_X   = 1,
  parameter int unsigned ABI_EN     = 1,
  localparam int unsigned REG_W     = $clog2(NUM_REGS)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_data,
  input  logic             new_character,
  input  logic [7:0]       incoming_ascii,
  output logic [REG_W-1:0] register,
  output logic [7:0]       term_char,
  output logic             done_flag,
  output logic             error_flag
);

  localparam int unsigned ACC_W = REG_W + 4;
  localparam logic [ACC_W-1:0] NUM_REGS_A = ACC_W'(NUM_REGS);
  localparam logic [1:0]       MAX_D      = 2'(MAX_DIGITS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PREFIX  = 3'd1;
  localparam logic [2:0] ST_DIGITS  = 3'd2;
  localparam logic [2:0] ST_ABI     = 3'd3;
  localparam logic [2:0] ST_ABI_END = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       count_q, count_d;
  logic             is_r_q, is_r_d;
  logic [23:0]      abi_str_q, abi_str_d;
  logic [1:0]       abi_len_q, abi_len_d;
  logic [2:0]       abi_val_q, abi_val_d;
  logic [REG_W-1:0] register_q, register_d;
  logic [7:0]       term_char_q, term_char_d;

  logic             is_digit, is_delim, is_blank;
  logic [7:0]       ch_fold;
  logic [3:0]       digit_val;
  logic [ACC_W-1:0] acc_next;

  assign ch_fold   = incoming_ascii | 8'h20;
  assign digit_val = incoming_ascii[3:0];
  assign is_digit  = (incoming_ascii >= 8'h30) && (incoming_ascii <= 8'h39);
  assign is_blank  = (incoming_ascii == 8'h20) || (incoming_ascii == 8'h09);
  assign is_delim  = is_blank || (incoming_ascii == 8'h2C) ||
                     (incoming_ascii == 8'h29) || (incoming_ascii == 8'h0A);
  assign acc_next  = (acc_q * ACC_W'(10)) + ACC_W'(digit_val);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    is_r_d      = is_r_q;
    abi_str_d   = abi_str_q;
    abi_len_d   = abi_len_q;
    abi_val_d   = abi_val_q;
    register_d  = register_q;
    term_char_d = term_char_q;

    if (!valid_data) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        // DONE shares IDLE's rules so a token may start in the pulse cycle
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (new_character) begin
            if (is_blank) begin
              state_d = ST_IDLE;
            end else if (ch_fold == 8'h72) begin
              state_d = ST_PREFIX;
              is_r_d  = 1'b1;
            end else if ((ACCEPT_X != 0) && (ch_fold == 8'h78)) begin
              state_d = ST_PREFIX;
              is_r_d  = 1'b0;
            end else if ((ABI_EN != 0) && (ch_fold == 8'h7A)) begin
              state_d   = ST_ABI;
              abi_str_d = 24'h6F7265;
              abi_len_d = 2'd3;
              abi_val_d = 3'd0;
            end else if ((ABI_EN != 0) && ((ch_fold == 8'h73) || (ch_fold == 8'h67) ||
                                           (ch_fold == 8'h74))) begin
              state_d   = ST_ABI;
              abi_str_d = 24'h000070;
              abi_len_d = 2'd1;
              abi_val_d = (ch_fold == 8'h73) ? 3'd2 : (ch_fold == 8'h67) ? 3'd3 : 3'd4;
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_PREFIX: begin
          if (new_character) begin
            // A single digit can already be out of range for very small register files
            if (is_digit && (ACC_W'(digit_val) < NUM_REGS_A)) begin
              state_d = ST_DIGITS;
              acc_d   = ACC_W'(digit_val);
              count_d = 2'd1;
            end else if ((ABI_EN != 0) && is_r_q && (ch_fold == 8'h61)) begin
              state_d = ST_ABI_END;
              acc_d   = ACC_W'(1);
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_DIGITS: begin
          if (new_character) begin
            if (is_digit) begin
              // acc_q == 0 here can only mean the first digit was a leading '0'
              if ((acc_q == '0) || (count_q >= MAX_D) || (acc_next >= NUM_REGS_A)) begin
                state_d = ST_ERROR;
              end else begin
                acc_d   = acc_next;
                count_d = 2'(count_q + 2'd1);
              end
            end else if (is_delim) begin
              state_d     = ST_DONE;
              register_d  = acc_q[REG_W-1:0];
              term_char_d = incoming_ascii;
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_ABI: begin
          if (new_character) begin
            if (ch_fold == abi_str_q[7:0]) begin
              if (abi_len_q == 2'd1) begin
                if (ACC_W'(abi_val_q) >= NUM_REGS_A) begin
                  state_d = ST_ERROR;
                end else begin
                  state_d = ST_ABI_END;
                  acc_d   = ACC_W'(abi_val_q);
                end
              end else begin
                abi_str_d = {8'h00, abi_str_q[23:8]};
                abi_len_d = 2'(abi_len_q - 2'd1);
              end
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_ABI_END: begin
          if (new_character) begin
            if (is_delim) begin
              state_d     = ST_DONE;
              register_d  = acc_q[REG_W-1:0];
              term_char_d = incoming_ascii;
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      is_r_q      <= 1'b0;
      abi_str_q   <= '0;
      abi_len_q   <= '0;
      abi_val_q   <= '0;
      register_q  <= '0;
      term_char_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      is_r_q      <= is_r_d;
      abi_str_q   <= abi_str_d;
      abi_len_q   <= abi_len_d;
      abi_val_q   <= abi_val_d;
      register_q  <= register_d;
      term_char_q <= term_char_d;
    end
  end

  assign register   = register_q;
  assign term_char  = term_char_q;
  assign done_flag  = (state_q == ST_DONE);
  assign error_flag = (state_q == ST_ERROR);

endmodule

// File: tb/tb_register_token_parser.sv
// Bench for register_token_parser: three parameterisations share one stimulus stream and
// are compared every cycle against a string-level token model.
module tb_register_token_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vd = 1'b0;
  logic       nc = 1'b0;
  logic [7:0] ch = 8'h00;

  logic [4:0] reg_a, reg_b;
  logic [1:0] reg_c;
  logic [7:0] term_a, term_b, term_c;
  logic       done_a, done_b, done_c, err_a, err_b, err_c;

  register_token_parser u_a (
    .clk_in(clk), .rst_n_in(rst_n), .valid_data(vd), .new_character(nc),
    .incoming_ascii(ch), .register(reg_a), .term_char(term_a),
    .done_flag(done_a), .error_flag(err_a));

  register_token_parser #(.ACCEPT_X(0)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .valid_data(vd), .new_character(nc),
    .incoming_ascii(ch), .register(reg_b), .term_char(term_b),
    .done_flag(done_b), .error_flag(err_b));

  register_token_parser #(.NUM_REGS(4)) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .valid_data(vd), .new_character(nc),
    .incoming_ascii(ch), .register(reg_c), .term_char(term_c),
    .done_flag(done_c), .error_flag(err_c));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int    cfg_nregs[3] = '{32, 32, 4};
  int    cfg_accx[3]  = '{1, 0, 1};
  int    cfg_maxd[3]  = '{2, 2, 2};
  string alias_name[5] = '{"zero", "ra", "sp", "gp", "tp"};

  logic [7:0] tok[3][8];
  int         tlen[3];
  bit         merr[3];
  bit         mdone[3];
  int         mreg[3];
  int         mterm[3];

  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? 8'(c + 8'h20) : c;
  endfunction

  function automatic bit delim(input logic [7:0] c);
    return c == 8'h20 || c == 8'h2C || c == 8'h09 || c == 8'h29 || c == 8'h0A;
  endfunction

  // 0: not the start of any legal token, 1: legal but incomplete, 2: complete token (val set)
  function automatic int classify(input int k, output int val);
    int    n, res, v, d, ln;
    bit    ok, m;
    string nm;
    n = tlen[k]; res = 0; val = 0;
    if (n >= 1 && (tok[k][0] == 8'h72 || (cfg_accx[k] != 0 && tok[k][0] == 8'h78))) begin
      d = n - 1; ok = 1; v = 0;
      if (d > cfg_maxd[k]) ok = 0;
      for (int i = 1; i < n; i++) begin
        if (tok[k][i] < 8'h30 || tok[k][i] > 8'h39) ok = 0;
        else v = v * 10 + int'(tok[k][i] - 8'h30);
      end
      if (d > 1 && tok[k][1] == 8'h30) ok = 0;
      if (v >= cfg_nregs[k]) ok = 0;
      if (ok) begin
        if (d == 0) res = 1;
        else begin res = 2; val = v; end
      end
    end
    for (int a = 0; a < 5; a++) begin
      nm = alias_name[a]; ln = nm.len();
      if (n >= 1 && n <= ln) begin
        m = 1;
        for (int i = 0; i < n; i++) if (tok[k][i] != 8'(nm[i])) m = 0;
        if (m) begin
          if (n < ln) begin if (res == 0) res = 1; end
          else if (a < cfg_nregs[k]) begin res = 2; val = a; end
        end
      end
    end
    return res;
  endfunction

  task automatic model_reset;
    for (int k = 0; k < 3; k++) begin
      tlen[k] = 0; merr[k] = 0; mdone[k] = 0; mreg[k] = 0; mterm[k] = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic n, input logic [7:0] c);
    int val;
    for (int k = 0; k < 3; k++) begin
      mdone[k] = 0;
      if (!v) begin
        merr[k] = 0; tlen[k] = 0;
      end else if (n && !merr[k]) begin
        if (tlen[k] == 0 && (c == 8'h20 || c == 8'h09)) begin
          // leading whitespace
        end else if (delim(c)) begin
          if (tlen[k] > 0 && classify(k, val) == 2) begin
            mdone[k] = 1; mreg[k] = val; mterm[k] = int'(c);
          end else merr[k] = 1;
          tlen[k] = 0;
        end else if (tlen[k] >= 8) begin
          merr[k] = 1; tlen[k] = 0;
        end else begin
          tok[k][tlen[k]] = fold(c);
          tlen[k]++;
          if (classify(k, val) == 0) begin merr[k] = 1; tlen[k] = 0; end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input int k, input logic d, input logic e,
                           input logic [31:0] r, input logic [7:0] t);
    check({nm, ".done"},  32'(d), 32'(mdone[k]));
    check({nm, ".error"}, 32'(e), 32'(merr[k]));
    check({nm, ".reg"},   r,      32'(mreg[k]));
    check({nm, ".term"},  32'(t), 32'(mterm[k]));
  endtask

  task automatic check_all;
    check_dut("a", 0, done_a, err_a, 32'(reg_a), term_a);
    check_dut("b", 1, done_b, err_b, 32'(reg_b), term_b);
    check_dut("c", 2, done_c, err_c, 32'(reg_c), term_c);
  endtask

  task automatic cycle(input logic v, input logic n, input logic [7:0] c);
    vd = v; nc = n; ch = c;
    @(posedge clk);
    model_step(v, n, c);
    #1;
    check_all();
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, 1'b1, 8'(s[i]));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic clear_session;
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] delims[5];
    logic [7:0] pfx[4];
    logic [7:0] c;
    string      nm;
    int         kind, v, a;

    delims = '{8'h20, 8'h2C, 8'h09, 8'h29, 8'h0A};
    pfx    = '{8'h72, 8'h52, 8'h78, 8'h58};

    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    send("r31,");  gap(2);
    send("  X7)"); gap(3); clear_session(); gap(1);
    send("r32 ");  clear_session();
    send("r01 ");  clear_session();
    send("r123");  clear_session();
    send("r,");    clear_session();
    send("r0\n");  gap(1);
    send("zero,ra,sp,gp,tp "); gap(1); clear_session();
    send("Gp\tR9)"); gap(1);
    send("r1,r2,"); gap(2);

    // asynchronous reset between clock edges, in the middle of a token
    send("r");
    vd = 1'b1; nc = 1'b1; ch = 8'h32;
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;
    send("r5 "); gap(1);

    for (int t = 0; t < 300; t++) begin
      q.delete();
      if ($urandom_range(0, 3) == 0) q.push_back(($urandom_range(0, 1) != 0) ? 8'h20 : 8'h09);
      kind = int'($urandom_range(0, 9));
      if (kind <= 4) begin
        q.push_back(pfx[$urandom_range(0, 3)]);
        if ($urandom_range(0, 9) == 0) q.push_back(8'h30);
        v = int'($urandom_range(0, 40));
        if (v >= 10) q.push_back(8'(8'h30 + v / 10));
        q.push_back(8'(8'h30 + v % 10));
        if ($urandom_range(0, 7) == 0) q.push_back(8'(8'h30 + $urandom_range(0, 9)));
      end else if (kind <= 7) begin
        a = int'($urandom_range(0, 4));
        nm = alias_name[a];
        for (int i = 0; i < nm.len(); i++) begin
          c = 8'(nm[i]);
          if ($urandom_range(0, 1) != 0) c = 8'(c - 8'h20);
          q.push_back(c);
        end
      end else begin
        q.push_back(8'($urandom_range(32, 126)));
      end
      q.push_back(delims[$urandom_range(0, 4)]);

      foreach (q[i]) begin
        if ($urandom_range(0, 3) == 0) cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 59) == 0) cycle(1'b0, 1'b1, q[i]);
        cycle(1'b1, 1'b1, q[i]);
      end
      if (merr[0] || merr[1] || merr[2] || $urandom_range(0, 5) == 0) clear_session();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_token_parser.md
Name: register_token_parser

Overview:
- Parametrised streaming parser for register operands in the assembler front end. Consumes one ASCII character per new_character strobe.
- Accepts numeric register tokens (r/R prefix, optionally x/X prefix, then 1..MAX_DIGITS decimal digits) and, optionally, the ABI aliases zero/ra/sp/gp/tp.
- Emits the register index with a one-cycle done pulse when a delimiter arrives, and raises a sticky error on malformed input.
- Sits between the character fetch stage and the instruction encoder. It re-arms automatically after each token, so a comma-separated operand list parses back-to-back.

Parameters:
- NUM_REGS, 32, number of architectural registers. Valid indices are 0..NUM_REGS-1. Must be at least 2.
- MAX_DIGITS, 2, maximum decimal digits after the prefix (1..3).
- ACCEPT_X, 1, when 1, x/X is accepted as a prefix in addition to r/R.
- ABI_EN, 1, when 1, the aliases zero=0, ra=1, sp=2, gp=3, tp=4 are accepted.
- REG_W (localparam), $clog2(NUM_REGS), width of the register output.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- valid_data  input  1  token session enable. Low forces IDLE synchronously and clears error.
- new_character  input  1  qualifies incoming_ascii for one cycle.
- incoming_ascii  input  8  character code.
- register  output  REG_W  parsed index. Valid while done_flag is high; holds its value otherwise.
- term_char  output  8  delimiter that ended the last successful token.
- done_flag  output  1  high exactly one cycle per accepted token.
- error_flag  output  1  high while in ERROR.

Behaviour:
- Reset (rst_n_in low, async): state=IDLE, register=0, term_char=0, internal accumulator=0, digit count=0, done_flag=0, error_flag=0.
- Only cycles with valid_data=1 and new_character=1 advance the FSM. valid_data=0 puts the FSM in IDLE next cycle from any state.
- Letters are case-folded (bit 5 forced high) before comparison. Digits are 0x30..0x39.
- Delimiter set: 0x20 space, 0x2C ',', 0x09 tab, 0x29 ')', 0x0A newline.
- FSM states: IDLE, PREFIX, DIGITS, ABI, ABI_END, DONE, ERROR. done_flag = (state==DONE). error_flag = (state==ERROR).
- IDLE:
  - space or tab: stay (leading whitespace is skipped).
  - 'r': PREFIX.
  - 'x' with ACCEPT_X=1: PREFIX.
  - z/s/g/t with ABI_EN=1: ABI, with the expected remaining string latched ("ero", "p", "p", "p").
  - Anything else: ERROR.
- PREFIX:
  - Digit: DIGITS, acc=digit, count=1.
  - 'a' after 'r' with ABI_EN=1: ABI_END, acc=1.
  - Anything else: ERROR.
- DIGITS:
  - Digit: acc = acc*10 + digit, computed at REG_W+4 bits, count+1.
  - The following go to ERROR on that same character: new acc >= NUM_REGS; count would exceed MAX_DIGITS; first digit was '0' (leading zero, e.g. "r01").
  - Delimiter: DONE, register<=acc[REG_W-1:0], term_char<=char.
  - Anything else: ERROR.
- ABI: each character must match the next expected letter, otherwise ERROR. After the last letter, go to ABI_END with acc set to the alias value.
- ABI_END:
  - Delimiter: DONE, same capture as DIGITS.
  - Anything else: ERROR.
  - An alias value >= NUM_REGS goes to ERROR at the final letter.
- DONE:
  - Lasts one cycle, then IDLE if no character arrives.
  - A character arriving in the DONE cycle is processed with IDLE rules, allowing zero-gap back-to-back tokens.
- ERROR: sticky, ignores characters. Cleared only by valid_data=0 or reset.
- Latency: done_flag rises the cycle after the delimiter is sampled.
- Reset mid-token discards all partial state.

Test Plan:
- "r31," on consecutive cycles -> done_flag for 1 cycle after ',', register=31, term_char=0x2C, error_flag=0.
- "  X7)" with ACCEPT_X=1 -> register=7, term_char=0x29. With ACCEPT_X=0 -> error_flag high after 'X', stays high until valid_data=0, then IDLE.
- "r32 " with NUM_REGS=32 -> ERROR on '2'. "r01 " -> ERROR on '1'. "r123" with MAX_DIGITS=2 -> ERROR on '3'. "r," -> ERROR on ','.
- "zero,ra,sp,gp,tp " with ABI_EN=1 -> five done pulses, register 0,1,2,3,4. Repeat with NUM_REGS=4 -> "tp" raises ERROR at 'p'.
- "r1,r2," with no idle gaps, where 'r' arrives in the DONE cycle -> two done pulses, register=1 then 2, no error.
- rst_n_in pulsed low asynchronously mid "r2" (between clock edges) -> outputs zero immediately. "r5 " afterwards -> register=5.
